// File: rtl/any1_pkg.sv
// Shared ANY-1 types: branch condition encodings and the resolved-branch record.
package any1_pkg;

  localparam int ANY1_WID  = 64;
  localparam int ANY1_TAGW = 6;

  typedef enum logic [2:0] {
    BR_EQ  = 3'd0,
    BR_NE  = 3'd1,
    BR_LT  = 3'd2,
    BR_GE  = 3'd3,
    BR_LTU = 3'd4,
    BR_GEU = 3'd5,
    BR_BS  = 3'd6,
    BR_BC  = 3'd7
  } BrCond;

  // pc holds the resolved (correct) next fetch address of the branch
  typedef struct packed {
    logic                 valid;
    logic                 taken;
    logic                 mispred;
    logic [ANY1_WID-1:0]  pc;
    logic [ANY1_TAGW-1:0] tag;
  } BrResult;

endpackage

// File: rtl/any1_branch_cond.sv
// Combinational branch condition evaluator for one lane.
// BS/BC test a single bit of a, selected by the low bits of b.
module any1_branch_cond import any1_pkg::*; #(
  parameter  int WID = ANY1_WID,
  localparam int BW  = $clog2(WID)
) (
  input  BrCond          i_cond,
  input  logic [WID-1:0] i_a,
  input  logic [WID-1:0] i_b,
  output logic           o_taken
);

  logic w_bit;
  assign w_bit = i_a[i_b[BW-1:0]];

  always_comb begin
    o_taken = 1'b0;
    case (i_cond)
      BR_EQ:   o_taken = (i_a == i_b);
      BR_NE:   o_taken = (i_a != i_b);
      BR_LT:   o_taken = ($signed(i_a) <  $signed(i_b));
      BR_GE:   o_taken = ($signed(i_a) >= $signed(i_b));
      BR_LTU:  o_taken = (i_a <  i_b);
      BR_GEU:  o_taken = (i_a >= i_b);
      BR_BS:   o_taken = w_bit;
      BR_BC:   o_taken = ~w_bit;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/any1_branch_unit.sv
// Two-stage multi-lane branch resolution: S1 registers conditions, S2 registers resolved PCs.
// Output stalls hold both stages; the oldest mispredicting lane redirects and squashes younger work.
module any1_branch_unit import any1_pkg::*; #(
  parameter  int WID        = ANY1_WID,
  parameter  int NCH        = 2,
  parameter  int DISPW      = 21,
  parameter  int TAGW       = ANY1_TAGW,
  parameter  int INSN_BYTES = 4,
  localparam int LW         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic [NCH-1:0]        in_valid_i,
  output logic                  in_ready_o,
  input  logic [3*NCH-1:0]      in_cond_i,
  input  logic [WID*NCH-1:0]    in_a_i,
  input  logic [WID*NCH-1:0]    in_b_i,
  input  logic [WID*NCH-1:0]    in_pc_i,
  input  logic [DISPW*NCH-1:0]  in_disp_i,
  input  logic [NCH-1:0]        in_pred_i,
  input  logic [TAGW*NCH-1:0]   in_tag_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [NCH-1:0]        out_lane_v_o,
  output logic [NCH-1:0]        out_taken_o,
  output logic [TAGW*NCH-1:0]   out_tag_o,
  output logic                  redirect_o,
  output logic [WID-1:0]        redirect_pc_o,
  output logic [TAGW-1:0]       redirect_tag_o,
  output logic [LW-1:0]         redirect_lane_o
);

  logic [NCH-1:0]   r_s1_v, r_s1_taken, r_s1_pred;
  logic [WID-1:0]   r_s1_pc   [NCH];
  logic [DISPW-1:0] r_s1_disp [NCH];
  logic [TAGW-1:0]  r_s1_tag  [NCH];
  BrResult          r_s2      [NCH];
  BrResult          w_s2_nxt  [NCH];

  logic [NCH-1:0] w_taken, w_lane_v;
  logic           w_found, w_s2_adv, w_redirect;
  logic [LW-1:0]  w_m;

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    any1_branch_cond #(.WID(WID)) u_cond (
      .i_cond  (BrCond'(in_cond_i[g*3 +: 3])),
      .i_a     (in_a_i[g*WID +: WID]),
      .i_b     (in_b_i[g*WID +: WID]),
      .o_taken (w_taken[g])
    );
  end

  // Lanes above the oldest mispredict are squashed; that lane itself is kept.
  always_comb begin
    w_found     = 1'b0;
    w_m         = '0;
    w_lane_v    = '0;
    out_taken_o = '0;
    out_tag_o   = '0;
    for (int l = 0; l < NCH; l++) begin
      if (!w_found) begin
        w_lane_v[l] = r_s2[l].valid;
        if (r_s2[l].valid && r_s2[l].mispred) begin
          w_found = 1'b1;
          w_m     = LW'(l);
        end
      end
    end
    for (int l = 0; l < NCH; l++) begin
      out_taken_o[l]             = w_lane_v[l] & r_s2[l].taken;
      out_tag_o[l*TAGW +: TAGW]  = w_lane_v[l] ? r_s2[l].tag : '0;
    end
  end

  assign out_valid_o     = |w_lane_v;
  assign out_lane_v_o    = w_lane_v;
  assign w_s2_adv        = ~(|w_lane_v) | out_ready_i;
  assign in_ready_o      = ~rst_i & (~(|r_s1_v) | w_s2_adv);
  assign w_redirect      = out_valid_o & out_ready_i & w_found;
  assign redirect_o      = w_redirect;
  assign redirect_pc_o   = w_redirect ? r_s2[w_m].pc  : '0;
  assign redirect_tag_o  = w_redirect ? r_s2[w_m].tag : '0;
  assign redirect_lane_o = w_redirect ? w_m           : '0;

  always_comb begin
    for (int l = 0; l < NCH; l++) begin
      w_s2_nxt[l].valid   = r_s1_v[l] & ~w_redirect;
      w_s2_nxt[l].taken   = r_s1_taken[l];
      w_s2_nxt[l].mispred = r_s1_taken[l] ^ r_s1_pred[l];
      w_s2_nxt[l].pc      = r_s1_taken[l]
                          ? r_s1_pc[l] + {{(WID-DISPW){r_s1_disp[l][DISPW-1]}}, r_s1_disp[l]}
                          : r_s1_pc[l] + WID'(INSN_BYTES);
      w_s2_nxt[l].tag     = r_s1_tag[l];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i || w_redirect) begin
      r_s1_v <= '0;
    end else if (in_ready_o) begin
      r_s1_v <= in_valid_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (in_ready_o) begin
      r_s1_taken <= w_taken;
      r_s1_pred  <= in_pred_i;
      for (int l = 0; l < NCH; l++) begin
        r_s1_pc[l]   <= in_pc_i[l*WID +: WID];
        r_s1_disp[l] <= in_disp_i[l*DISPW +: DISPW];
        r_s1_tag[l]  <= in_tag_i[l*TAGW +: TAGW];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      for (int l = 0; l < NCH; l++) r_s2[l].valid <= 1'b0;
    end else if (w_s2_adv) begin
      for (int l = 0; l < NCH; l++) r_s2[l] <= w_s2_nxt[l];
    end
  end

endmodule

// File: tb/tb_any1_branch_unit.sv
// Directed self-checking bench for any1_branch_unit (NCH=2, WID=64).
module tb_any1_branch_unit;
  import any1_pkg::*;

  logic         clk_i = 1'b0;
  logic         rst_i, flush_i, out_ready_i;
  logic [1:0]   in_valid_i, in_pred_i;
  logic [5:0]   in_cond_i;
  logic [127:0] in_a_i, in_b_i, in_pc_i;
  logic [41:0]  in_disp_i;
  logic [11:0]  in_tag_i;
  logic         in_ready_o, out_valid_o, redirect_o;
  logic [1:0]   out_lane_v_o, out_taken_o;
  logic [11:0]  out_tag_o;
  logic [63:0]  redirect_pc_o;
  logic [5:0]   redirect_tag_o;
  logic [0:0]   redirect_lane_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  any1_branch_unit dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_cond_i(in_cond_i),
    .in_a_i(in_a_i), .in_b_i(in_b_i), .in_pc_i(in_pc_i), .in_disp_i(in_disp_i),
    .in_pred_i(in_pred_i), .in_tag_i(in_tag_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_lane_v_o(out_lane_v_o),
    .out_taken_o(out_taken_o), .out_tag_o(out_tag_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
    .redirect_tag_o(redirect_tag_o), .redirect_lane_o(redirect_lane_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_in();
    in_valid_i = '0; in_pred_i = '0; in_cond_i = '0; in_a_i = '0; in_b_i = '0;
    in_pc_i = '0; in_disp_i = '0; in_tag_i = '0;
  endtask

  task automatic set_lane(input int l, input logic [2:0] c, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] pc, input logic [20:0] d,
                          input logic p, input logic [5:0] t);
    in_valid_i[l]         = 1'b1;
    in_cond_i[l*3 +: 3]   = c;
    in_a_i[l*64 +: 64]    = a;
    in_b_i[l*64 +: 64]    = b;
    in_pc_i[l*64 +: 64]   = pc;
    in_disp_i[l*21 +: 21] = d;
    in_pred_i[l]          = p;
    in_tag_i[l*6 +: 6]    = t;
  endtask

  // Two correctly predicted lanes (EQ 0,0 taken, pred=1) carrying tags t0/t1.
  task automatic ok_group(input logic [5:0] t0, input logic [5:0] t1);
    clear_in();
    set_lane(0, BR_EQ, 64'h0, 64'h0, 64'h1000, 21'h10, 1'b1, t0);
    set_lane(1, BR_EQ, 64'h0, 64'h0, 64'h2000, 21'h10, 1'b1, t1);
  endtask

  initial begin
    clear_in();
    rst_i = 1'b1; flush_i = 1'b0; out_ready_i = 1'b1;
    step(); step();
    #1;
    chk("rst_in_ready", 64'(in_ready_o), 64'h0);
    chk("rst_out_valid", 64'(out_valid_o), 64'h0);
    chk("rst_redirect", 64'(redirect_o), 64'h0);
    chk("rst_lane_v", 64'(out_lane_v_o), 64'h0);
    chk("rst_taken", 64'(out_taken_o), 64'h0);
    rst_i = 1'b0;
    #1;
    chk("rel_in_ready", 64'(in_ready_o), 64'h1);
    step();

    // Signed vs unsigned compare of -1 and 1
    set_lane(0, BR_LT,  64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h1000, 21'h20, 1'b1, 6'd1);
    set_lane(1, BR_LTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h1004, 21'h20, 1'b0, 6'd2);
    step(); clear_in(); #1;
    chk("cmp_lat1_valid", 64'(out_valid_o), 64'h0);
    step(); #1;
    chk("cmp_valid", 64'(out_valid_o), 64'h1);
    chk("cmp_taken", 64'(out_taken_o), 64'h1);
    chk("cmp_lane_v", 64'(out_lane_v_o), 64'h3);
    chk("cmp_tag", 64'(out_tag_o), 64'h081);
    chk("cmp_redirect", 64'(redirect_o), 64'h0);
    step();

    // BS / BC on bit 63 (b upper bits ignored)
    set_lane(0, BR_BS, 64'h8000_0000_0000_0000, 64'h13F, 64'h3000, 21'h4, 1'b1, 6'd3);
    set_lane(1, BR_BC, 64'h8000_0000_0000_0000, 64'h13F, 64'h3004, 21'h4, 1'b0, 6'd4);
    step(); clear_in(); step(); #1;
    chk("bit_taken", 64'(out_taken_o), 64'h1);
    chk("bit_redirect", 64'(redirect_o), 64'h0);
    step();

    // Target wrap: taken, predicted not-taken
    set_lane(0, BR_EQ, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 21'd8, 1'b0, 6'd5);
    step(); clear_in(); step(); #1;
    chk("wrap_redirect", 64'(redirect_o), 64'h1);
    chk("wrap_pc", redirect_pc_o, 64'h4);
    chk("wrap_lane", 64'(redirect_lane_o), 64'h0);
    chk("wrap_tag", 64'(redirect_tag_o), 64'd5);
    chk("wrap_lane_v", 64'(out_lane_v_o), 64'h1);
    step();

    // Fall-through wrap on lane 1, lane 0 correct
    set_lane(0, BR_EQ, 64'h0, 64'h0, 64'h200, 21'h10, 1'b1, 6'd8);
    set_lane(1, BR_NE, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 21'd8, 1'b1, 6'd9);
    step(); clear_in(); step(); #1;
    chk("ft_redirect", 64'(redirect_o), 64'h1);
    chk("ft_pc", redirect_pc_o, 64'h0);
    chk("ft_lane", 64'(redirect_lane_o), 64'h1);
    chk("ft_tag", 64'(redirect_tag_o), 64'd9);
    chk("ft_lane_v", 64'(out_lane_v_o), 64'h3);
    chk("ft_taken", 64'(out_taken_o), 64'h1);
    step();

    // Squash: lane0 mispredicts, younger group in S1, third offered in redirect cycle
    clear_in();
    set_lane(0, BR_EQ, 64'd5, 64'd5, 64'h100, 21'h40, 1'b0, 6'd10);
    set_lane(1, BR_EQ, 64'd5, 64'd5, 64'h200, 21'h40, 1'b1, 6'd11);
    step();
    ok_group(6'd20, 6'd21);
    step();
    ok_group(6'd30, 6'd31);
    #1;
    chk("sq_in_ready", 64'(in_ready_o), 64'h1);
    chk("sq_redirect", 64'(redirect_o), 64'h1);
    chk("sq_pc", redirect_pc_o, 64'h140);
    chk("sq_lane", 64'(redirect_lane_o), 64'h0);
    chk("sq_tag", 64'(redirect_tag_o), 64'd10);
    chk("sq_lane_v", 64'(out_lane_v_o), 64'h1);
    step(); clear_in(); #1;
    chk("sq_gone1", 64'(out_valid_o), 64'h0);
    step();
    chk("sq_gone2", 64'(out_valid_o), 64'h0);
    step();
    chk("sq_gone3", 64'(out_valid_o), 64'h0);

    // Backpressure: out_ready low for 5 cycles while streaming
    out_ready_i = 1'b0;
    ok_group(6'd3, 6'd4);
    step();
    ok_group(6'd5, 6'd6);
    step();
    ok_group(6'd7, 6'd8);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready", 64'(in_ready_o), 64'h0);
      chk("bp_valid", 64'(out_valid_o), 64'h1);
      chk("bp_tag", 64'(out_tag_o), 64'h103);
      chk("bp_lane_v", 64'(out_lane_v_o), 64'h3);
      step();
    end
    out_ready_i = 1'b1;
    #1;
    chk("bp_rel_ready", 64'(in_ready_o), 64'h1);
    chk("bp_g1", 64'(out_tag_o), 64'h103);
    step(); clear_in(); #1;
    chk("bp_g2", 64'(out_tag_o), 64'h185);
    step();
    chk("bp_g3", 64'(out_tag_o), 64'h207);
    step();
    chk("bp_empty", 64'(out_valid_o), 64'h0);

    // Flush with both stages full
    out_ready_i = 1'b0;
    ok_group(6'd12, 6'd13);
    step();
    ok_group(6'd14, 6'd15);
    step();
    flush_i = 1'b1;
    #1;
    chk("fl_same_cycle", 64'(out_valid_o), 64'h1);
    step();
    flush_i = 1'b0; clear_in(); out_ready_i = 1'b1; #1;
    chk("fl_next", 64'(out_valid_o), 64'h0);
    step();
    chk("fl_s1_gone", 64'(out_valid_o), 64'h0);

    // Flush discards a group accepted in the same cycle
    ok_group(6'd16, 6'd17);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0; clear_in();
    step(); step();
    chk("fl_accept_gone", 64'(out_valid_o), 64'h0);

    // Reset mid-stream
    ok_group(6'd18, 6'd19);
    step();
    ok_group(6'd22, 6'd23);
    step();
    rst_i = 1'b1;
    ok_group(6'd24, 6'd25);
    #1;
    chk("mrst_in_ready", 64'(in_ready_o), 64'h0);
    step(); #1;
    chk("mrst_valid", 64'(out_valid_o), 64'h0);
    chk("mrst_lane_v", 64'(out_lane_v_o), 64'h0);
    chk("mrst_taken", 64'(out_taken_o), 64'h0);
    chk("mrst_redirect", 64'(redirect_o), 64'h0);
    chk("mrst_rpc", redirect_pc_o, 64'h0);
    chk("mrst_rtag", 64'(redirect_tag_o), 64'h0);
    chk("mrst_rlane", 64'(redirect_lane_o), 64'h0);
    chk("mrst_ready", 64'(in_ready_o), 64'h0);
    rst_i = 1'b0; clear_in(); #1;
    chk("mrst_rel_ready", 64'(in_ready_o), 64'h1);
    step();
    chk("mrst_drop1", 64'(out_valid_o), 64'h0);
    step();
    chk("mrst_drop2", 64'(out_valid_o), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
